// File: rtl/apb_intercon_rr.sv
// apb_intercon_rr: N-master / M-slave APB3 interconnect.
// Round-robin arbitration across masters, base/mask address decode across
// slaves. The winning request is latched at grant time and replayed to the
// slave as a clean SETUP/ACCESS pair. Unmapped addresses, slave errors and
// slave timeouts are reported back to the master on S_PSLVERR.
module apb_intercon_rr #(
  parameter int BUS_WIDTH      = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int MASTER_PORTS   = 4,
  parameter int SLAVE_PORTS    = 8,
  // slice i = base address of slave i (default: slave i lives at i<<8)
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_BASE = {
    16'h0700, 16'h0600, 16'h0500, 16'h0400,
    16'h0300, 16'h0200, 16'h0100, 16'h0000},
  // slice i = decode mask of slave i
  parameter logic [SLAVE_PORTS*BUS_WIDTH-1:0] SLAVE_MASK = {SLAVE_PORTS{16'hFF00}},
  // ACCESS cycles allowed before abort; 0 disables the timeout
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                             clk,
  input  logic                             reset,
  // master side
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0]  S_PADDR,
  input  logic [MASTER_PORTS-1:0]            S_PWRITE,
  input  logic [MASTER_PORTS-1:0]            S_PSELx,
  input  logic [MASTER_PORTS-1:0]            S_PENABLE,
  input  logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PWDATA,
  output logic [MASTER_PORTS*DATA_WIDTH-1:0] S_PRDATA,
  output logic [MASTER_PORTS-1:0]            S_PREADY,
  output logic [MASTER_PORTS-1:0]            S_PSLVERR,
  // slave side
  output logic [BUS_WIDTH-1:0]               M_PADDR,
  output logic                               M_PWRITE,
  output logic [SLAVE_PORTS-1:0]             M_PSELx,
  output logic                               M_PENABLE,
  output logic [DATA_WIDTH-1:0]              M_PWDATA,
  input  logic [SLAVE_PORTS*DATA_WIDTH-1:0]  M_PRDATA,
  input  logic [SLAVE_PORTS-1:0]             M_PREADY,
  input  logic [SLAVE_PORTS-1:0]             M_PSLVERR
);

  localparam int MW = (MASTER_PORTS > 1) ? $clog2(MASTER_PORTS) : 1;
  localparam int SW = (SLAVE_PORTS > 1) ? $clog2(SLAVE_PORTS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_ERR} state_e;

  // PENABLE from the masters carries no information we need: the slave-side
  // phases are regenerated here from the latched request.
  logic unused_penable;
  assign unused_penable = &{1'b0, S_PENABLE};

  state_e                  state_q, state_d;
  logic [MW-1:0]           last_q, last_d;       // last granted master
  logic [MW-1:0]           gnt_q, gnt_d;         // master owning the transfer
  logic [SW-1:0]           sel_idx_q, sel_idx_d; // index of selected slave
  logic [SLAVE_PORTS-1:0]  psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic [BUS_WIDTH-1:0]    paddr_q, paddr_d;
  logic                    pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic                    req_any;
  logic [MW-1:0]           gnt_pick;
  logic [BUS_WIDTH-1:0]    req_addr;
  logic                    dec_hit;
  logic [SW-1:0]           dec_idx;

  // Round-robin pick: first requester after last_q, searching cyclically.
  // The loop walks the distances far-to-near so the nearest requester is
  // the final assignment.
  always_comb begin
    int m;
    m        = 0;
    req_any  = |S_PSELx;
    gnt_pick = last_q;
    for (int k = MASTER_PORTS; k >= 1; k--) begin
      m = (int'(last_q) + k) % MASTER_PORTS;
      if (S_PSELx[m]) gnt_pick = MW'(m);
    end
  end

  // Address decode of the picked master; lowest slave index wins on overlap.
  always_comb begin
    req_addr = S_PADDR[int'(gnt_pick)*BUS_WIDTH +: BUS_WIDTH];
    dec_hit  = 1'b0;
    dec_idx  = '0;
    for (int i = SLAVE_PORTS - 1; i >= 0; i--) begin
      if ((req_addr & SLAVE_MASK[i*BUS_WIDTH +: BUS_WIDTH]) ==
          SLAVE_BASE[i*BUS_WIDTH +: BUS_WIDTH]) begin
        dec_hit = 1'b1;
        dec_idx = SW'(i);
      end
    end
  end

  // Next-state and next-output computation for the transfer sequencer.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    sel_idx_d = sel_idx_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        psel_d    = '0;
        penable_d = 1'b0;
        cnt_d     = '0;
        if (req_any) begin
          gnt_d    = gnt_pick;
          last_d   = gnt_pick;
          paddr_d  = req_addr;
          pwrite_d = S_PWRITE[gnt_pick];
          pwdata_d = S_PWDATA[int'(gnt_pick)*DATA_WIDTH +: DATA_WIDTH];
          if (dec_hit) begin
            sel_idx_d       = dec_idx;
            psel_d[dec_idx] = 1'b1;
            state_d         = ST_SETUP;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        // ready always beats the timeout on the same cycle
        if (M_PREADY[sel_idx_q]) begin
          psel_d    = '0;
          penable_d = 1'b0;
          cnt_d     = '0;
          state_d   = ST_IDLE;
        end else if (TIMEOUT_CYCLES > 0) begin
          if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            psel_d    = '0;
            penable_d = 1'b0;
            cnt_d     = '0;
            state_d   = ST_ERR;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_ERR: begin
        psel_d    = '0;
        penable_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sequencer state and registered slave-side outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      last_q    <= MW'(MASTER_PORTS - 1);
      gnt_q     <= '0;
      sel_idx_q <= '0;
      psel_q    <= '0;
      penable_q <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      sel_idx_q <= sel_idx_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      paddr_q   <= paddr_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      cnt_q     <= cnt_d;
    end
  end

  assign M_PADDR   = paddr_q;
  assign M_PWRITE  = pwrite_q;
  assign M_PSELx   = psel_q;
  assign M_PENABLE = penable_q;
  assign M_PWDATA  = pwdata_q;

  // Response path: only the granted master's slice is ever driven. ACCESS
  // passes the selected slave straight through; ERR fabricates an error.
  always_comb begin
    S_PREADY  = '0;
    S_PSLVERR = '0;
    S_PRDATA  = '0;
    case (state_q)
      ST_ACCESS: begin
        S_PREADY[gnt_q]  = M_PREADY[sel_idx_q];
        S_PSLVERR[gnt_q] = M_PSLVERR[sel_idx_q];
        S_PRDATA[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH] =
          M_PRDATA[int'(sel_idx_q)*DATA_WIDTH +: DATA_WIDTH];
      end
      ST_ERR: begin
        S_PREADY[gnt_q]  = 1'b1;
        S_PSLVERR[gnt_q] = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_intercon_rr.sv
// Directed bench for apb_intercon_rr (4 masters, 8 slaves, timeout 4).
// Inputs change #1 after the rising edge; outputs are checked in the same
// window, after the registered state has settled.
module tb_apb_intercon_rr;

  localparam int BW = 16;
  localparam int DW = 16;
  localparam int NM = 4;
  localparam int NS = 8;

  logic             clk;
  logic             reset;
  logic [NM*BW-1:0] S_PADDR;
  logic [NM-1:0]    S_PWRITE;
  logic [NM-1:0]    S_PSELx;
  logic [NM-1:0]    S_PENABLE;
  logic [NM*DW-1:0] S_PWDATA;
  logic [NM*DW-1:0] S_PRDATA;
  logic [NM-1:0]    S_PREADY;
  logic [NM-1:0]    S_PSLVERR;
  logic [BW-1:0]    M_PADDR;
  logic             M_PWRITE;
  logic [NS-1:0]    M_PSELx;
  logic             M_PENABLE;
  logic [DW-1:0]    M_PWDATA;
  logic [NS*DW-1:0] M_PRDATA;
  logic [NS-1:0]    M_PREADY;
  logic [NS-1:0]    M_PSLVERR;

  int tests = 0;
  int fails = 0;

  apb_intercon_rr #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx),
    .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA),
    .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx),
    .M_PENABLE(M_PENABLE), .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA),
    .M_PREADY(M_PREADY), .M_PSLVERR(M_PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic mreq(input int m, input logic on, input logic [BW-1:0] a,
                      input logic w, input logic [DW-1:0] d);
    S_PSELx[m]             = on;
    S_PENABLE[m]           = 1'b0;
    S_PADDR[m*BW +: BW]    = a;
    S_PWRITE[m]            = w;
    S_PWDATA[m*DW +: DW]   = d;
  endtask

  task automatic sresp(input int s, input logic rdy, input logic err, input logic [DW-1:0] d);
    M_PREADY[s]          = rdy;
    M_PSLVERR[s]         = err;
    M_PRDATA[s*DW +: DW] = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_psel"},   64'(M_PSELx),   64'h0);
    chk({tag, "_pen"},    64'(M_PENABLE), 64'h0);
    chk({tag, "_paddr"},  64'(M_PADDR),   64'h0);
    chk({tag, "_pwrite"}, 64'(M_PWRITE),  64'h0);
    chk({tag, "_pwdata"}, 64'(M_PWDATA),  64'h0);
    chk({tag, "_srdy"},   64'(S_PREADY),  64'h0);
    chk({tag, "_serr"},   64'(S_PSLVERR), 64'h0);
    chk({tag, "_srdata"}, S_PRDATA,       64'h0);
  endtask

  initial begin
    reset     = 1'b0;
    S_PADDR   = '0;
    S_PWRITE  = '0;
    S_PSELx   = '0;
    S_PENABLE = '0;
    S_PWDATA  = '0;
    M_PRDATA  = '0;
    M_PREADY  = '0;
    M_PSLVERR = '0;

    // ---- reset state ----
    #12;
    chk_all_zero("rst");
    @(negedge clk);
    reset = 1'b1;
    tick();

    // ---- contention: all four write to slave2, served 0,1,2,3 ----
    for (int i = 0; i < NM; i++) mreq(i, 1'b1, 16'h0200 + 16'(i), 1'b1, 16'hA000 + 16'(i));
    sresp(2, 1'b1, 1'b0, 16'h0);
    #1;
    chk("cont_idle_psel", 64'(M_PSELx), 64'h0);
    for (int t = 0; t < NM; t++) begin
      tick(); // SETUP
      chk("cont_setup_psel", 64'(M_PSELx),   64'h04);
      chk("cont_setup_pen",  64'(M_PENABLE), 64'h0);
      chk("cont_addr",       64'(M_PADDR),   64'h0200 + 64'(t));
      chk("cont_wdata",      64'(M_PWDATA),  64'hA000 + 64'(t));
      chk("cont_pwrite",     64'(M_PWRITE),  64'h1);
      tick(); // ACCESS
      chk("cont_access_pen", 64'(M_PENABLE), 64'h1);
      chk("cont_rdy",        64'(S_PREADY),  64'(1) << t);
      S_PSELx[t] = 1'b0;
      tick(); // IDLE gap
      chk("cont_gap_psel",   64'(M_PSELx),   64'h0);
      chk("cont_gap_rdy",    64'(S_PREADY),  64'h0);
    end
    tick();
    chk("cont_no_repeat", 64'(M_PSELx), 64'h0);
    sresp(2, 1'b0, 1'b0, 16'h0);

    // ---- zero-wait read: M0 reads 0x0104 from slave1 ----
    mreq(0, 1'b1, 16'h0104, 1'b0, 16'h0);
    sresp(1, 1'b1, 1'b0, 16'hBEEF);
    #1;
    chk("rd_idle_rdy_ignored", 64'(S_PREADY), 64'h0);
    tick(); // cycle 1
    chk("rd_c1_psel", 64'(M_PSELx),   64'h02);
    chk("rd_c1_pen",  64'(M_PENABLE), 64'h0);
    chk("rd_c1_rdy",  64'(S_PREADY),  64'h0);
    chk("rd_c1_pwr",  64'(M_PWRITE),  64'h0);
    tick(); // cycle 2
    chk("rd_c2_psel",  64'(M_PSELx),   64'h02);
    chk("rd_c2_pen",   64'(M_PENABLE), 64'h1);
    chk("rd_c2_rdy",   64'(S_PREADY),  64'h1);
    chk("rd_c2_rdata", S_PRDATA,       64'h0000_0000_0000_BEEF);
    chk("rd_c2_err",   64'(S_PSLVERR), 64'h0);
    S_PSELx[0] = 1'b0;
    tick(); // cycle 3
    chk("rd_c3_psel", 64'(M_PSELx),   64'h0);
    chk("rd_c3_pen",  64'(M_PENABLE), 64'h0);
    sresp(1, 1'b0, 1'b0, 16'h0);

    // ---- unmapped: M2 accesses 0x0900 ----
    for (int s = 0; s < NS; s++) sresp(s, 1'b0, 1'b0, 16'h1111 * 16'(s + 1));
    mreq(2, 1'b1, 16'h0900, 1'b0, 16'h0);
    tick(); // cycle 1: ERR
    chk("unm_psel",  64'(M_PSELx),   64'h0);
    chk("unm_pen",   64'(M_PENABLE), 64'h0);
    chk("unm_rdy",   64'(S_PREADY),  64'h4);
    chk("unm_err",   64'(S_PSLVERR), 64'h4);
    chk("unm_rdata", S_PRDATA,       64'h0);
    S_PSELx[2] = 1'b0;
    tick();
    chk("unm_after_rdy", 64'(S_PREADY),  64'h0);
    chk("unm_after_err", 64'(S_PSLVERR), 64'h0);

    // ---- timeout: M1 to slave3 which never answers ----
    mreq(1, 1'b1, 16'h0300, 1'b1, 16'h5A5A);
    tick(); // SETUP
    chk("tmo_setup_psel", 64'(M_PSELx), 64'h08);
    for (int a = 0; a < 4; a++) begin
      tick(); // ACCESS a
      chk("tmo_acc_psel", 64'(M_PSELx),   64'h08);
      chk("tmo_acc_pen",  64'(M_PENABLE), 64'h1);
      chk("tmo_acc_rdy",  64'(S_PREADY),  64'h0);
    end
    tick(); // ERR
    chk("tmo_err_psel", 64'(M_PSELx),   64'h0);
    chk("tmo_err_pen",  64'(M_PENABLE), 64'h0);
    chk("tmo_err_rdy",  64'(S_PREADY),  64'h2);
    chk("tmo_err_err",  64'(S_PSLVERR), 64'h2);
    S_PSELx[1] = 1'b0;
    tick();
    chk("tmo_idle_rdy",  64'(S_PREADY), 64'h0);
    chk("tmo_idle_psel", 64'(M_PSELx),  64'h0);

    // ---- wait states + slave error: M3 to slave5, M0 queues behind ----
    mreq(3, 1'b1, 16'h0500, 1'b0, 16'h0);
    tick(); // SETUP
    chk("ws_setup_psel", 64'(M_PSELx), 64'h20);
    tick(); // ACCESS wait 1
    chk("ws_w1_rdy", 64'(S_PREADY),  64'h0);
    chk("ws_w1_err", 64'(S_PSLVERR), 64'h0);
    S_PSELx[3] = 1'b0; // granted master drops out mid-transfer
    mreq(0, 1'b1, 16'h0104, 1'b0, 16'h1234);
    tick(); // ACCESS wait 2
    chk("ws_w2_psel",  64'(M_PSELx),  64'h20);
    chk("ws_w2_paddr", 64'(M_PADDR),  64'h0500);
    chk("ws_w2_rdy",   64'(S_PREADY), 64'h0);
    tick(); // ACCESS wait 3
    chk("ws_w3_rdy", 64'(S_PREADY), 64'h0);
    tick(); // ACCESS, slave answers
    sresp(5, 1'b1, 1'b1, 16'h0);
    #1;
    chk("ws_done_rdy", 64'(S_PREADY),  64'h8);
    chk("ws_done_err", 64'(S_PSLVERR), 64'h8);
    tick(); // IDLE; slave5 still signalling
    chk("ws_once_rdy",  64'(S_PREADY),  64'h0);
    chk("ws_once_err",  64'(S_PSLVERR), 64'h0);
    chk("ws_once_psel", 64'(M_PSELx),   64'h0);
    sresp(5, 1'b0, 1'b0, 16'h0);
    tick(); // SETUP for queued M0
    chk("rr_next_psel", 64'(M_PSELx), 64'h02);
    sresp(1, 1'b0, 1'b0, 16'hBEEF);
    tick(); // ACCESS, slave1 waiting
    chk("pre_rst_pen", 64'(M_PENABLE), 64'h1);

    // ---- reset mid-ACCESS ----
    reset = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    mreq(2, 1'b1, 16'h0600, 1'b0, 16'h0);
    @(negedge clk);
    reset = 1'b1;
    tick(); // SETUP: master 0 wins over master 2
    chk("post_rst_psel", 64'(M_PSELx), 64'h02);
    sresp(1, 1'b1, 1'b0, 16'hBEEF);
    tick(); // ACCESS
    chk("post_rst_rdy",   64'(S_PREADY), 64'h1);
    chk("post_rst_rdata", S_PRDATA,      64'h0000_0000_0000_BEEF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
